// File: rtl/gcd_stein_resp_pkg.sv
// Shared types and constants for the binary-GCD responder.
// Both the RTL and the bench import this package.
package gcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } gcd_state_e;

  localparam int GCD_WIDTH = 4;

  // Worst-case number of RUN cycles for a given operand width.
  function automatic int max_run_cycles(input int w);
    return 2 * w + 1;
  endfunction

endpackage

// File: rtl/gcd_stein_resp_if.sv
// Operand-request / busy / valid bus between a GCD initiator and a responder.
//
// Handshake:
//  - The initiator drives req_i with op_a_i and op_b_i.
//  - The operands are taken at the rising edge where req_i=1 and busy_o=0.
//  - While busy_o=1, req_i is ignored, so the initiator must hold or retry.
//  - valid_o is a one-cycle pulse. result_val_o holds the last result until
//    the next completion.
interface gcd_stein_resp_if #(parameter int WIDTH = 4);
  logic             req_i;
  logic [WIDTH-1:0] op_a_i;
  logic [WIDTH-1:0] op_b_i;
  logic             busy_o;
  logic             valid_o;
  logic [WIDTH-1:0] result_val_o;

  modport master (output req_i, op_a_i, op_b_i,
                  input  busy_o, valid_o, result_val_o);
  modport slave  (input  req_i, op_a_i, op_b_i,
                  output busy_o, valid_o, result_val_o);
endinterface

// File: rtl/gcd_stein_resp_step.sv
// One combinational Stein reduction step on (a, b, k).
// done flags a==b, and result is then the scaled GCD.
module gcd_stein_step #(
  parameter int WIDTH = 4,
  parameter int KW    = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [KW-1:0]    k,
  output logic [WIDTH-1:0] a_nxt,
  output logic [WIDTH-1:0] b_nxt,
  output logic [KW-1:0]    k_nxt,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  always_comb begin
    a_nxt  = a;
    b_nxt  = b;
    k_nxt  = k;
    done   = (a == b);
    result = a << k;
    if (!done) begin
      if (!a[0] && !b[0]) begin
        a_nxt = a >> 1;
        b_nxt = b >> 1;
        k_nxt = k + KW'(1);
      end else if (!a[0]) begin
        a_nxt = a >> 1;
      end else if (!b[0]) begin
        b_nxt = b >> 1;
      end else if (a > b) begin
        // Both operands are odd here, so the difference is even and the shift is exact.
        a_nxt = (a - b) >> 1;
      end else begin
        b_nxt = (b - a) >> 1;
      end
    end
  end

endmodule

// File: rtl/gcd_stein_resp.sv
// Binary (Stein) GCD responder: accepts operands, reduces one step per cycle,
// and pulses valid_o with the registered result.
module gcd_stein_resp
  import gcd_pkg::*;
#(
  parameter int WIDTH = GCD_WIDTH,
  parameter int KW    = $clog2(WIDTH + 1)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  gcd_stein_resp_if.slave    bus,
  output gcd_state_e         state_o
);

  gcd_state_e       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
  logic [KW-1:0]    k_q, k_d;

  logic [WIDTH-1:0] step_a, step_b, step_result;
  logic [KW-1:0]    step_k;
  logic             step_done;

  gcd_stein_step #(.WIDTH(WIDTH), .KW(KW)) u_step (
    .a      (a_q),
    .b      (b_q),
    .k      (k_q),
    .a_nxt  (step_a),
    .b_nxt  (step_b),
    .k_nxt  (step_k),
    .done   (step_done),
    .result (step_result)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      k_q      <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      k_q      <= k_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    k_d      = k_q;
    result_d = result_q;
    case (state_q)
      IDLE, DONE: begin
        // A request in DONE is accepted in the same cycle that the old result is reported.
        if (bus.req_i) begin
          a_d = bus.op_a_i;
          b_d = bus.op_b_i;
          k_d = '0;
          if (bus.op_a_i == '0 || bus.op_b_i == '0) begin
            result_d = bus.op_a_i | bus.op_b_i;
            state_d  = DONE;
          end else begin
            state_d  = RUN;
          end
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (step_done) begin
          result_d = step_result;
          state_d  = DONE;
        end else begin
          a_d = step_a;
          b_d = step_b;
          k_d = step_k;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy_o       = (state_q == RUN);
  assign bus.valid_o      = (state_q == DONE);
  assign bus.result_val_o = result_q;
  assign state_o          = state_q;

endmodule

// File: doc/gcd_stein_resp.md
Name: gcd_stein_resp

Overview:
Responder for the operand-request / busy / valid GCD protocol. It accepts a pair of unsigned operands from an initiator and computes their GCD iteratively with the binary (Stein) algorithm, one reduction step per cycle. It returns the result with a one-cycle valid pulse. It sits behind the operand FIFOs and the initiator, as a drop-in alternative responder with a parameterised width.

Parameters:
WIDTH, 4, operand and result width in bits (>= 2)
KW, $clog2(WIDTH+1), width of the common power-of-two shift counter

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset; synchronous, active-high
req_i  in  1  request; operands are sampled when req_i=1 and busy_o=0
op_a_i  in  WIDTH  operand A (unsigned)
op_b_i  in  WIDTH  operand B (unsigned)
busy_o  out  1  high while a computation is in progress; requests are ignored
valid_o  out  1  one-cycle pulse; result_val_o is valid for the completed request
result_val_o  out  WIDTH  GCD of the last completed request; held until the next completion

Behaviour:
- Reset (rst_i=1 at an edge): state IDLE; busy_o=0, valid_o=0, result_val_o=0; internal a, b, k cleared. Reset overrides req_i.
- Reset mid-operation aborts the computation. The aborted request produces no valid_o.
- States: IDLE, RUN, DONE. busy_o=1 only in RUN. valid_o=1 only in DONE.
- Acceptance: in IDLE or DONE, with req_i=1, at the clock edge:
  - a<=op_a_i, b<=op_b_i, k<=0.
  - If op_a_i==0 or op_b_i==0: result_val_o<=op_a_i|op_b_i, go to DONE. gcd(0,0)=0.
  - Otherwise go to RUN.
- req_i while busy_o=1 is ignored. The initiator must hold or retry.
- Back-to-back: a request in the DONE cycle is accepted. valid_o for the old result and acceptance of the new request happen in the same cycle.
- RUN, one step per cycle, evaluated in this priority order:
  1. a==b: result_val_o<=a<<k (truncated to WIDTH; cannot overflow), go to DONE.
  2. a, b both even: a>>=1, b>>=1, k+=1.
  3. a even: a>>=1.
  4. b even: b>>=1.
  5. a>b: a<=(a-b)>>1; else b<=(b-a)>>1. Both odd, so the difference is even and the shift is exact.
- Subtraction is unsigned WIDTH bits, only ever performed larger-minus-smaller, so there is no wrap.
- Latency bound: RUN lasts at most 2*WIDTH+1 cycles. Every non-terminal step shortens a or b by at least one bit.
- DONE lasts exactly one cycle. Without a new req_i it returns to IDLE. valid_o drops and result_val_o is held.
- No outputs are combinational from inputs. All outputs are registered or decoded from state.

Decomposition:
- gcd_pkg holds:
  - state enum gcd_state_e {IDLE, RUN, DONE}
  - default WIDTH localparam
  - helper function for the maximum-cycle bound, used by the bench timeout
- Optional sub-module gcd_stein_step: combinational next-(a,b,k) plus done flag, so the step logic is unit-testable. The FSM and registers stay in gcd_stein_resp.

Test Plan:
- Reset: hold rst_i 2 cycles with req_i=1 -> busy_o=0, valid_o=0, result_val_o=0; no acceptance.
- Timing, gcd(12,8), WIDTH=4:
  - Stimulus: req pulse with a=12, b=8.
  - Response: busy_o=1 for exactly cycles 1..5 after the acceptance edge.
  - Response: valid_o=1 in cycle 6 only; result_val_o=4 from then on.
- Zero operands: (0,9) -> valid_o one cycle after acceptance, result 9, busy_o never high. (0,0) -> result 0.
- Equal/coprime: (7,7) -> result 7 after a 1-cycle RUN. (15,14) -> result 1.
- Busy/back-to-back: req (12,8), then req (9,6) while busy -> ignored, only one valid with 4. Then req (9,6) in the DONE cycle -> accepted, next valid gives 3.
- Abort, then exhaustive check:
  - Assert rst_i during RUN of (12,8) -> no valid_o. A following (10,4) -> 2.
  - Exhaustive: all 256 pairs match a reference gcd, each within 2*WIDTH+2 cycles.
